// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: inst/data SRAM-like ports to one AXI3 master.
// One outstanding read, one outstanding write, data reads win over fetch.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   inst_sram_*           fetch port (reads only, id 0)
//   data_sram_*           load/store port (id 1)
//   ar*/r*                AXI read address / read data channels
//   aw*/w*/b*             AXI write address / data / response channels
module cpu_axi_bridge #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_sram_req,
  input  logic            inst_sram_wr,
  input  logic [1:0]      inst_sram_size,
  input  logic [31:0]     inst_sram_addr,
  input  logic [3:0]      inst_sram_wstrb,
  input  logic [31:0]     inst_sram_wdata,
  output logic            inst_sram_addr_ok,
  output logic            inst_sram_data_ok,
  output logic [31:0]     inst_sram_rdata,
  input  logic            data_sram_req,
  input  logic            data_sram_wr,
  input  logic [1:0]      data_sram_size,
  input  logic [31:0]     data_sram_addr,
  input  logic [3:0]      data_sram_wstrb,
  input  logic [31:0]     data_sram_wdata,
  output logic            data_sram_addr_ok,
  output logic            data_sram_data_ok,
  output logic [31:0]     data_sram_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  localparam logic [ID_W-1:0] INST_ID = '0;
  localparam logic [ID_W-1:0] DATA_ID = ID_W'(1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_R
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_AW,
    W_B
  } w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [31:0]     ar_addr_q;
  logic [2:0]      ar_size_q;
  logic [ID_W-1:0] ar_id_q;
  logic [31:0]     aw_addr_q;
  logic [2:0]      aw_size_q;
  logic [31:0]     w_data_q;
  logic [3:0]      w_strb_q;
  logic            aw_done;
  logic            w_done;

  logic r_idle;
  logic w_idle;
  logic data_busy;
  logic inst_acc;
  logic data_rd_acc;
  logic data_wr_acc;
  logic r_hs;

  logic unused_ok;
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb,
                       inst_sram_wdata, rresp, rlast,
                       bid, bresp};

  assign r_idle = (r_state == R_IDLE);
  assign w_idle = (w_state == W_IDLE);

  // Any data txn in flight blocks the data port so its
  // data_ok pulses come back in request order.
  assign data_busy = (!r_idle && ar_id_q == DATA_ID)
                   || !w_idle;

  assign data_rd_acc = data_sram_req && !data_sram_wr
                    && r_idle && !data_busy;
  assign data_wr_acc = data_sram_req && data_sram_wr
                    && w_idle && !data_busy;
  assign inst_acc    = inst_sram_req && r_idle
                    && !(data_sram_req && !data_sram_wr);

  assign inst_sram_addr_ok = inst_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;

  assign r_hs = rvalid && rready;

  assign inst_sram_data_ok = r_hs && (rid == INST_ID);
  assign data_sram_data_ok = (r_hs && (rid == DATA_ID))
                          || (bvalid && bready);
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arsize  = ar_size_q;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = DATA_ID;
  assign awaddr  = aw_addr_q;
  assign awsize  = aw_size_q;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = DATA_ID;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      ar_size_q <= '0;
      ar_id_q   <= '0;
    end else begin
      r_state <= r_next;
      if (data_rd_acc) begin
        ar_addr_q <= data_sram_addr;
        ar_size_q <= {1'b0, data_sram_size};
        ar_id_q   <= DATA_ID;
      end else if (inst_acc) begin
        ar_addr_q <= inst_sram_addr;
        ar_size_q <= {1'b0, inst_sram_size};
        ar_id_q   <= INST_ID;
      end
    end
  end

  always_comb begin
    r_next  = r_state;
    arvalid = 1'b0;
    rready  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (inst_acc || data_rd_acc) r_next = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_R;
      end
      R_R: begin
        rready = 1'b1;
        if (rvalid) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      aw_size_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      w_state <= w_next;
      if (data_wr_acc) begin
        aw_addr_q <= data_sram_addr;
        aw_size_q <= {1'b0, data_sram_size};
        w_data_q  <= data_sram_wdata;
        w_strb_q  <= data_sram_wstrb;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end else if (w_state == W_AW) begin
        if (awready) aw_done <= 1'b1;
        if (wready)  w_done  <= 1'b1;
      end
    end
  end

  // AW and W handshake independently; the phase ends once
  // both have completed, possibly in the same cycle.
  always_comb begin
    w_next  = w_state;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (data_wr_acc) w_next = W_AW;
      end
      W_AW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready))
          w_next = W_B;
      end
      W_B: begin
        bready = 1'b1;
        if (bvalid) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: random core + AXI slave stimulus,
// transaction-level model and scoreboard for cpu_axi_bridge.
module tb_cpu_axi_bridge;

  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            inst_sram_req, inst_sram_wr;
  logic [1:0]      inst_sram_size;
  logic [31:0]     inst_sram_addr, inst_sram_wdata;
  logic [3:0]      inst_sram_wstrb;
  logic            inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0]     inst_sram_rdata;
  logic            data_sram_req, data_sram_wr;
  logic [1:0]      data_sram_size;
  logic [31:0]     data_sram_addr, data_sram_wdata;
  logic [3:0]      data_sram_wstrb;
  logic            data_sram_addr_ok, data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic [ID_W-1:0] arid, rid, awid, wid, bid;
  logic [31:0]     araddr, rdata, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, arprot, awsize, awprot;
  logic [1:0]      arburst, arlock, rresp;
  logic [1:0]      awburst, awlock, bresp;
  logic [3:0]      arcache, awcache, wstrb;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready;
  logic            bvalid, bready;

  cpu_axi_bridge #(.ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]     addr;
    logic [2:0]      size;
    logic [ID_W-1:0] id;
  } ar_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
  } aw_t;

  typedef struct {
    bit          wr;
    logic [31:0] data;
  } cpl_t;

  ar_t         ar_q[$];
  aw_t         aw_q[$];
  logic [31:0] inst_q[$];
  cpl_t        data_q[$];
  int          rd_cnt, wr_cnt;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic bad(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // monitor -> driver event flags, sampled at negedge
  bit              acc_i, acc_d, ev_ar, ev_r, ev_aw, ev_w, ev_b;
  logic [31:0]     cap_addr;
  logic [ID_W-1:0] cap_id;
  bit              aw_m, w_m;
  bit              exp_i, exp_d;
  ar_t             m_ar;
  cpl_t            m_cp;

  always @(negedge clk) begin
    acc_i = 0; acc_d = 0; ev_ar = 0; ev_r = 0;
    ev_aw = 0; ev_w = 0; ev_b = 0;
    if (reset) begin
      ar_q.delete(); aw_q.delete();
      inst_q.delete(); data_q.delete();
      rd_cnt = 0; wr_cnt = 0; aw_m = 0; w_m = 0;
    end else begin
      exp_i = inst_sram_req && rd_cnt == 0
           && !(data_sram_req && !data_sram_wr);
      exp_d = data_sram_req && data_q.size() == 0
           && (data_sram_wr ? wr_cnt == 0 : rd_cnt == 0);
      chk("inst_addr_ok", inst_sram_addr_ok, exp_i);
      chk("data_addr_ok", data_sram_addr_ok, exp_d);
      acc_i = inst_sram_addr_ok;
      acc_d = data_sram_addr_ok;

      if (rvalid) chk("rready", rready, 1);
      if (bvalid) chk("bready", bready, 1);
      chk("inst_data_ok", inst_sram_data_ok,
          rvalid && rid == 0);
      chk("data_data_ok", data_sram_data_ok,
          (rvalid && rid == 1) || bvalid);

      if (inst_sram_data_ok) begin
        if (inst_q.size() == 0) bad("inst_data_ok_extra");
        else chk("inst_rdata", inst_sram_rdata,
                 inst_q.pop_front());
      end
      if (data_sram_data_ok) begin
        if (data_q.size() == 0) bad("data_data_ok_extra");
        else begin
          m_cp = data_q.pop_front();
          chk("data_kind_wr", bvalid, m_cp.wr);
          if (!m_cp.wr)
            chk("data_rdata", data_sram_rdata, m_cp.data);
        end
      end

      ev_ar = arvalid && arready;
      if (ev_ar) begin
        if (ar_q.size() == 0) bad("ar_extra");
        else begin
          m_ar = ar_q.pop_front();
          chk("araddr", araddr, m_ar.addr);
          chk("arsize", arsize, m_ar.size);
          chk("arid", arid, m_ar.id);
        end
        cap_addr = araddr;
        cap_id   = arid;
      end

      if (aw_m) chk("awvalid_dropped", awvalid, 0);
      if (w_m)  chk("wvalid_dropped", wvalid, 0);
      ev_aw = awvalid && awready;
      ev_w  = wvalid && wready;
      if ((ev_aw || ev_w) && aw_q.size() == 0) bad("aw_w_extra");
      else begin
        if (ev_aw) begin
          chk("awaddr", awaddr, aw_q[0].addr);
          chk("awsize", awsize, aw_q[0].size);
          chk("awid", awid, 1);
          aw_m = 1;
        end
        if (ev_w) begin
          chk("wdata", wdata, aw_q[0].data);
          chk("wstrb", wstrb, aw_q[0].strb);
          chk("wlast", wlast, 1);
          chk("wid", wid, 1);
          w_m = 1;
        end
        if (aw_m && w_m) begin
          void'(aw_q.pop_front());
          aw_m = 0; w_m = 0;
        end
      end

      ev_r = rvalid && rready;
      ev_b = bvalid && bready;
      if (ev_r) rd_cnt--;
      if (ev_b) wr_cnt--;

      if (inst_sram_addr_ok) begin
        ar_q.push_back('{inst_sram_addr,
                         {1'b0, inst_sram_size}, '0});
        inst_q.push_back(mem_rd(inst_sram_addr));
        rd_cnt++;
      end
      if (data_sram_addr_ok) begin
        if (data_sram_wr) begin
          aw_q.push_back('{data_sram_addr,
                           {1'b0, data_sram_size},
                           data_sram_wdata, data_sram_wstrb});
          data_q.push_back('{1'b1, 32'h0});
          wr_cnt++;
        end else begin
          ar_q.push_back('{data_sram_addr,
                           {1'b0, data_sram_size}, ID_W'(1)});
          data_q.push_back('{1'b0, mem_rd(data_sram_addr)});
          rd_cnt++;
        end
      end
    end
  end

  function automatic logic [31:0] rnd_addr();
    logic [31:0] base;
    base = $urandom_range(0, 1) ? 32'h1C00_0000 : 32'h0000_8000;
    return base + ($urandom_range(0, 255) << 2);
  endfunction

  bit              r_pend, aw_s, w_s, b_pend;
  int              r_wait, b_wait;
  logic [31:0]     r_addr;
  logic [ID_W-1:0] r_id;

  initial begin
    mem[32'h1C00_0000] = 32'h0280_0C0C;
    reset = 1;
    {inst_sram_req, inst_sram_wr, inst_sram_size} = '0;
    {inst_sram_addr, inst_sram_wstrb, inst_sram_wdata} = '0;
    {data_sram_req, data_sram_wr, data_sram_size} = '0;
    {data_sram_addr, data_sram_wstrb, data_sram_wdata} = '0;
    {arready, rid, rdata, rresp, rlast, rvalid} = '0;
    {awready, wready, bid, bresp, bvalid} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wlast", wlast, 1);
    chk("rst_arburst", arburst, 1);
    chk("rst_arlen", arlen, 0);

    // fetch latency: accept N, arvalid N+1, rvalid/ok N+3
    @(posedge clk); #1;
    reset = 0;
    rlast = 1;
    arready = 1;
    inst_sram_req = 1;
    inst_sram_addr = 32'h1C00_0000;
    inst_sram_size = 2;
    @(negedge clk);
    chk("t1_addr_ok", inst_sram_addr_ok, 1);
    @(posedge clk); #1;
    inst_sram_req = 0;
    @(negedge clk);
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1C00_0000);
    chk("t1_arsize", arsize, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_ok_early", inst_sram_data_ok, 0);
    @(posedge clk); #1;
    rvalid = 1; rid = 0; rdata = 32'h0280_0C0C;
    @(negedge clk);
    chk("t1_data_ok", inst_sram_data_ok, 1);
    chk("t1_rdata", inst_sram_rdata, 32'h0280_0C0C);
    @(posedge clk); #1;
    rvalid = 0;

    // parallel fetch + store, then reset in R_R / W_AW
    inst_sram_req = 1;
    inst_sram_addr = 32'h1C00_0040;
    data_sram_req = 1; data_sram_wr = 1;
    data_sram_addr = 32'h0000_8000; data_sram_size = 2;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t6_inst_acc", inst_sram_addr_ok, 1);
    chk("t6_data_acc", data_sram_addr_ok, 1);
    @(posedge clk); #1;
    inst_sram_req = 0; data_sram_req = 0;
    @(negedge clk);
    chk("t6_awvalid", awvalid, 1);
    chk("t6_wvalid", wvalid, 1);
    @(posedge clk); #1;
    reset = 1; arready = 0;
    @(negedge clk);
    chk("t6_in_rr", rready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_arvalid", arvalid, 0);
    chk("t6_rst_rready", rready, 0);
    chk("t6_rst_awvalid", awvalid, 0);
    chk("t6_rst_wvalid", wvalid, 0);
    chk("t6_rst_bready", bready, 0);
    @(posedge clk); #1;
    reset = 0;
    inst_sram_req = 1;
    inst_sram_addr = 32'h1C00_0080;
    @(negedge clk);
    chk("t6_post_acc", inst_sram_addr_ok, 1);

    r_pend = 0; aw_s = 0; w_s = 0; b_pend = 0;
    for (int c = 0; c < 3100; c++) begin
      @(posedge clk); #1;
      if (inst_sram_req && acc_i) inst_sram_req = 0;
      if (!inst_sram_req && c < 3000
          && $urandom_range(0, 2) == 0) begin
        inst_sram_req  = 1;
        inst_sram_addr = rnd_addr();
        inst_sram_size = 2'($urandom_range(0, 2));
      end
      if (data_sram_req && acc_d) data_sram_req = 0;
      if (!data_sram_req && c < 3000
          && $urandom_range(0, 2) == 0) begin
        data_sram_req   = 1;
        data_sram_wr    = 1'($urandom_range(0, 1));
        data_sram_addr  = rnd_addr();
        data_sram_size  = 2'($urandom_range(0, 2));
        data_sram_wstrb = 4'($urandom);
        data_sram_wdata = $urandom;
      end

      if (ev_r) rvalid = 0;
      if (ev_ar) begin
        r_pend = 1;
        r_wait = $urandom_range(0, 3);
        r_addr = cap_addr;
        r_id   = cap_id;
      end
      if (r_pend) begin
        if (r_wait == 0) begin
          rvalid = 1; rid = r_id; rdata = mem_rd(r_addr);
          r_pend = 0;
        end else r_wait--;
      end
      arready = 1'($urandom_range(0, 1));

      if (ev_b) bvalid = 0;
      if (ev_aw) aw_s = 1;
      if (ev_w)  w_s = 1;
      if (aw_s && w_s) begin
        aw_s = 0; w_s = 0;
        b_pend = 1;
        b_wait = $urandom_range(0, 3);
      end
      if (b_pend) begin
        if (b_wait == 0) begin
          bvalid = 1; bid = ID_W'(1); bresp = 0;
          b_pend = 0;
        end else b_wait--;
      end
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    chk("drain_inst", inst_q.size(), 0);
    chk("drain_data", data_q.size(), 0);
    chk("drain_ar", ar_q.size(), 0);
    chk("drain_aw", aw_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
